video_bus_ctrl: RTL and testbench

VIDEO_BUS_CTRL -- requirements
Module: video_bus_ctrl

---
 rtl/video_bus_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_video_bus_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_bus_ctrl.sv
// video_bus_ctrl: splits one host bus between N_SLOTS register slots and a frame buffer write port.
// Latency: slot strobes one cycle after the request; read data two cycles after; frame writes pass through a FIFO_DEPTH FIFO.
// Backpressure: video_ready drops when the frame FIFO is full; frame writes offered while full are dropped and latch ovf_err. Slot accesses never stall.
//
// Ports:
//   clk, reset_n                 clock and async active-low reset
//   video_cs/wr/rd/addr/wr_data  host request; video_addr[FB_AW] picks frame buffer (1) or slot (0)
//   video_rd_data/rd_valid       read return, valid two cycles after the read
//   video_ready, ovf_err         frame FIFO not full; sticky dropped-frame-write flag
//   frame_*                      frame buffer write request, held until frame_ready
//   slot_*                       one-hot slot selects/strobes with shared address/data, per-slot read data
//
// Build option: define VIDEO_BUS_CTRL_READBACK_EN to include the read path.
// Without it, reads create no slot strobe and the read outputs are tied to zero.

module video_bus_ctrl #(
    parameter int N_SLOTS    = 8,
    parameter int REG_AW     = 14,
    parameter int FB_AW      = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     video_cs,
    input  logic                     video_wr,
    input  logic                     video_rd,
    input  logic [FB_AW:0]           video_addr,
    input  logic [31:0]              video_wr_data,
    output logic [31:0]              video_rd_data,
    output logic                     video_rd_valid,
    output logic                     video_ready,
    output logic                     ovf_err,
    output logic                     frame_cs,
    output logic                     frame_wr,
    output logic [FB_AW-1:0]         frame_addr,
    output logic [31:0]              frame_wr_data,
    input  logic                     frame_ready,
    output logic [N_SLOTS-1:0]       slot_cs_array,
    output logic [N_SLOTS-1:0]       slot_mem_wr_array,
    output logic [N_SLOTS-1:0]       slot_mem_rd_array,
    output logic [REG_AW-1:0]        slot_reg_addr,
    output logic [31:0]              slot_wr_data,
    input  logic [N_SLOTS-1:0][31:0] slot_rd_data_array
);

    localparam int SW = $clog2(N_SLOTS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    logic              w_is_fb;
    logic [SW-1:0]     w_slot_idx;
    logic [N_SLOTS-1:0] w_onehot;
    logic              w_slot_wr;
    logic              w_slot_rd;
    logic              w_push_req;

    assign w_is_fb    = video_addr[FB_AW];
    assign w_slot_idx = video_addr[REG_AW+SW-1:REG_AW];
    assign w_onehot   = {{(N_SLOTS-1){1'b0}}, 1'b1} << w_slot_idx;
    // A write strobe wins over a simultaneous read strobe.
    assign w_slot_wr  = video_cs & ~w_is_fb & video_wr;
    assign w_push_req = video_cs &  w_is_fb & video_wr;

`ifdef VIDEO_BUS_CTRL_READBACK_EN
    logic w_fb_rd;
    assign w_slot_rd = video_cs & ~w_is_fb & ~video_wr & video_rd;
    assign w_fb_rd   = video_cs &  w_is_fb & ~video_wr & video_rd;
`else
    assign w_slot_rd = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Slot side: registered strobes, valid for exactly one cycle
    // ---------------------------------------------------------------
    logic [N_SLOTS-1:0] r_slot_cs;
    logic [N_SLOTS-1:0] r_slot_wr;
    logic [REG_AW-1:0]  r_slot_addr;
    logic [31:0]        r_slot_wdat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_cs   <= '0;
            r_slot_wr   <= '0;
            r_slot_addr <= '0;
            r_slot_wdat <= '0;
        end else begin
            r_slot_cs <= (w_slot_wr | w_slot_rd) ? w_onehot : '0;
            r_slot_wr <= w_slot_wr ? w_onehot : '0;
            if (w_slot_wr | w_slot_rd) begin
                r_slot_addr <= video_addr[REG_AW-1:0];
                r_slot_wdat <= video_wr_data;
            end
        end
    end

    assign slot_cs_array     = r_slot_cs;
    assign slot_mem_wr_array = r_slot_wr;
    assign slot_reg_addr     = r_slot_addr;
    assign slot_wr_data      = r_slot_wdat;

    // ---------------------------------------------------------------
    // Read return path
    // ---------------------------------------------------------------
`ifdef VIDEO_BUS_CTRL_READBACK_EN
    logic [N_SLOTS-1:0] r_slot_rd;
    logic               r_p1_vld;
    logic               r_p1_fb;
    logic [SW-1:0]      r_p1_slot;
    logic               r_rd_vld;
    logic [31:0]        r_rd_dat;

    // Stage 1 remembers which slot was strobed; stage 2 captures that
    // slot's combinational read data while its strobe is live.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot_rd <= '0;
            r_p1_vld  <= 1'b0;
            r_p1_fb   <= 1'b0;
            r_p1_slot <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_dat  <= '0;
        end else begin
            r_slot_rd <= w_slot_rd ? w_onehot : '0;
            r_p1_vld  <= w_slot_rd | w_fb_rd;
            r_p1_fb   <= w_fb_rd;
            r_p1_slot <= w_slot_idx;
            r_rd_vld  <= r_p1_vld;
            if (r_p1_vld) begin
                r_rd_dat <= r_p1_fb ? 32'h0 : slot_rd_data_array[r_p1_slot];
            end
        end
    end

    assign slot_mem_rd_array = r_slot_rd;
    assign video_rd_data     = r_rd_dat;
    assign video_rd_valid    = r_rd_vld;

    logic w_unused;
    assign w_unused = ^video_addr;
`else
    assign slot_mem_rd_array = '0;
    assign video_rd_data     = '0;
    assign video_rd_valid    = 1'b0;

    logic w_unused;
    assign w_unused = ^{video_addr, video_rd, slot_rd_data_array};
`endif

    // ---------------------------------------------------------------
    // Frame write FIFO
    // ---------------------------------------------------------------
    logic [FB_AW+31:0] r_fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic [FB_AW+31:0] w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_pop   = ~w_empty & frame_ready;
    // When full, a push is still taken if the head leaves on the same edge;
    // the freed slot is the one the write pointer already addresses.
    assign w_push  = w_push_req & (~w_full | w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req & w_full & ~w_pop) r_ovf <= 1'b1;
        end
    end

    // Storage needs no reset: the outputs below are gated by the count.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_wr_ptr] <= {video_addr[FB_AW-1:0], video_wr_data};
    end

    assign w_head        = r_fifo_mem[r_rd_ptr];
    assign frame_cs      = ~w_empty;
    assign frame_wr      = ~w_empty;
    assign frame_addr    = w_empty ? '0 : w_head[FB_AW+31:32];
    assign frame_wr_data = w_empty ? '0 : w_head[31:0];
    assign video_ready   = ~w_full;
    assign ovf_err       = r_ovf;

endmodule

// File: tb/tb_video_bus_ctrl.sv
// Directed bench for video_bus_ctrl with default parameters.
// Inputs change 1ns after a rising edge; outputs are checked in the same window.

module tb_video_bus_ctrl;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              video_cs;
    logic              video_wr;
    logic              video_rd;
    logic [20:0]       video_addr;
    logic [31:0]       video_wr_data;
    logic [31:0]       video_rd_data;
    logic              video_rd_valid;
    logic              video_ready;
    logic              ovf_err;
    logic              frame_cs;
    logic              frame_wr;
    logic [19:0]       frame_addr;
    logic [31:0]       frame_wr_data;
    logic              frame_ready;
    logic [7:0]        slot_cs_array;
    logic [7:0]        slot_mem_wr_array;
    logic [7:0]        slot_mem_rd_array;
    logic [13:0]       slot_reg_addr;
    logic [31:0]       slot_wr_data;
    logic [7:0][31:0]  slot_rd_data_array;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    video_bus_ctrl dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .video_cs           (video_cs),
        .video_wr           (video_wr),
        .video_rd           (video_rd),
        .video_addr         (video_addr),
        .video_wr_data      (video_wr_data),
        .video_rd_data      (video_rd_data),
        .video_rd_valid     (video_rd_valid),
        .video_ready        (video_ready),
        .ovf_err            (ovf_err),
        .frame_cs           (frame_cs),
        .frame_wr           (frame_wr),
        .frame_addr         (frame_addr),
        .frame_wr_data      (frame_wr_data),
        .frame_ready        (frame_ready),
        .slot_cs_array      (slot_cs_array),
        .slot_mem_wr_array  (slot_mem_wr_array),
        .slot_mem_rd_array  (slot_mem_rd_array),
        .slot_reg_addr      (slot_reg_addr),
        .slot_wr_data       (slot_wr_data),
        .slot_rd_data_array (slot_rd_data_array)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        video_cs      = 1'b0;
        video_wr      = 1'b0;
        video_rd      = 1'b0;
        video_addr    = '0;
        video_wr_data = '0;
    endtask

    task automatic do_reset();
        idle_bus();
        frame_ready = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle_bus();
        frame_ready        = 1'b0;
        slot_rd_data_array = '0;
        reset_n            = 1'b0;
        #2;
        n_tests++; if (video_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", video_ready); end
        n_tests++; if (frame_cs !== 1'b0) begin n_fail++; $display("FAIL rst_frame_cs: got %b exp 0", frame_cs); end
        n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b exp 0", ovf_err); end
        n_tests++; if (slot_cs_array !== 8'h00) begin n_fail++; $display("FAIL rst_slot_cs: got %h exp 00", slot_cs_array); end
        n_tests++; if (video_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b exp 0", video_rd_valid); end
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_slot_write();
        video_cs = 1'b1; video_wr = 1'b1; video_addr = 21'h0C005; video_wr_data = 32'hDEADBEEF;
        tick();
        idle_bus();
        n_tests++; if (slot_cs_array !== 8'h08) begin n_fail++; $display("FAIL wr_cs: got %h exp 08", slot_cs_array); end
        n_tests++; if (slot_mem_wr_array !== 8'h08) begin n_fail++; $display("FAIL wr_strobe: got %h exp 08", slot_mem_wr_array); end
        n_tests++; if (slot_reg_addr !== 14'h0005) begin n_fail++; $display("FAIL wr_addr: got %h exp 0005", slot_reg_addr); end
        n_tests++; if (slot_wr_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_data: got %h exp deadbeef", slot_wr_data); end
        n_tests++; if (frame_cs !== 1'b0) begin n_fail++; $display("FAIL wr_no_frame: got %b exp 0", frame_cs); end
        tick();
        n_tests++; if (slot_cs_array !== 8'h00) begin n_fail++; $display("FAIL wr_cs_t2: got %h exp 00", slot_cs_array); end
        n_tests++; if (slot_mem_wr_array !== 8'h00) begin n_fail++; $display("FAIL wr_strobe_t2: got %h exp 00", slot_mem_wr_array); end
    endtask

    task automatic test_wr_and_rd();
        video_cs = 1'b1; video_wr = 1'b1; video_rd = 1'b1; video_addr = 21'h04010; video_wr_data = 32'h00C0FFEE;
        tick();
        idle_bus();
        n_tests++; if (slot_mem_wr_array !== 8'h02) begin n_fail++; $display("FAIL both_wr: got %h exp 02", slot_mem_wr_array); end
        n_tests++; if (slot_mem_rd_array !== 8'h00) begin n_fail++; $display("FAIL both_rd: got %h exp 00", slot_mem_rd_array); end
        n_tests++; if (slot_reg_addr !== 14'h0010) begin n_fail++; $display("FAIL both_addr: got %h exp 0010", slot_reg_addr); end
        tick();
        n_tests++; if (video_rd_valid !== 1'b0) begin n_fail++; $display("FAIL both_no_valid: got %b exp 0", video_rd_valid); end
    endtask

    task automatic test_cs_low();
        video_cs = 1'b0; video_wr = 1'b1; video_addr = 21'h08001; video_wr_data = 32'h1;
        tick();
        idle_bus();
        n_tests++; if (slot_cs_array !== 8'h00) begin n_fail++; $display("FAIL cslow_cs: got %h exp 00", slot_cs_array); end
        n_tests++; if (slot_mem_wr_array !== 8'h00) begin n_fail++; $display("FAIL cslow_wr: got %h exp 00", slot_mem_wr_array); end
    endtask

`ifdef VIDEO_BUS_CTRL_READBACK_EN
    task automatic test_read();
        slot_rd_data_array[0] = 32'hAAAA0000;
        slot_rd_data_array[1] = 32'hBBBB1111;
        slot_rd_data_array[2] = 32'h12345678;
        video_cs = 1'b1; video_rd = 1'b1; video_addr = 21'h08000;
        tick();
        idle_bus();
        n_tests++; if (slot_mem_rd_array !== 8'h04) begin n_fail++; $display("FAIL rd_strobe: got %h exp 04", slot_mem_rd_array); end
        n_tests++; if (slot_cs_array !== 8'h04) begin n_fail++; $display("FAIL rd_cs: got %h exp 04", slot_cs_array); end
        n_tests++; if (video_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_early: got %b exp 0", video_rd_valid); end
        tick();
        n_tests++; if (video_rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b exp 1", video_rd_valid); end
        n_tests++; if (video_rd_data !== 32'h12345678) begin n_fail++; $display("FAIL rd_data: got %h exp 12345678", video_rd_data); end
        tick();
        n_tests++; if (video_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse: got %b exp 0", video_rd_valid); end
        // back-to-back reads of slots 0, 1, 2
        video_cs = 1'b1; video_rd = 1'b1; video_addr = 21'h00000;
        tick();
        video_addr = 21'h04000;
        tick();
        video_addr = 21'h08000;
        n_tests++; if (video_rd_valid !== 1'b1 || video_rd_data !== 32'hAAAA0000) begin n_fail++; $display("FAIL b2b_0: got %b/%h exp 1/aaaa0000", video_rd_valid, video_rd_data); end
        tick();
        idle_bus();
        n_tests++; if (video_rd_valid !== 1'b1 || video_rd_data !== 32'hBBBB1111) begin n_fail++; $display("FAIL b2b_1: got %b/%h exp 1/bbbb1111", video_rd_valid, video_rd_data); end
        tick();
        n_tests++; if (video_rd_valid !== 1'b1 || video_rd_data !== 32'h12345678) begin n_fail++; $display("FAIL b2b_2: got %b/%h exp 1/12345678", video_rd_valid, video_rd_data); end
        tick();
        n_tests++; if (video_rd_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b exp 0", video_rd_valid); end
        // frame buffer read returns zero
        video_cs = 1'b1; video_rd = 1'b1; video_addr = 21'h100020;
        tick();
        idle_bus();
        n_tests++; if (slot_cs_array !== 8'h00) begin n_fail++; $display("FAIL fbrd_cs: got %h exp 00", slot_cs_array); end
        tick();
        n_tests++; if (video_rd_valid !== 1'b1 || video_rd_data !== 32'h0) begin n_fail++; $display("FAIL fbrd: got %b/%h exp 1/00000000", video_rd_valid, video_rd_data); end
        tick();
    endtask
`else
    task automatic test_read();
        slot_rd_data_array[2] = 32'h12345678;
        video_cs = 1'b1; video_rd = 1'b1; video_addr = 21'h08000;
        tick();
        idle_bus();
        n_tests++; if (slot_mem_rd_array !== 8'h00) begin n_fail++; $display("FAIL nord_strobe: got %h exp 00", slot_mem_rd_array); end
        n_tests++; if (slot_cs_array !== 8'h00) begin n_fail++; $display("FAIL nord_cs: got %h exp 00", slot_cs_array); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (video_rd_valid !== 1'b0 || video_rd_data !== 32'h0) begin n_fail++; $display("FAIL nord_valid: cycle %0d got %b/%h exp 0/00000000", i, video_rd_valid, video_rd_data); end
        end
    endtask
`endif

    task automatic test_frame_overflow();
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            video_cs = 1'b1; video_wr = 1'b1;
            video_addr = 21'h100000 + 21'(i); video_wr_data = 32'hF0000000 + 32'(i);
            tick();
            n_tests++; if (video_ready !== (i < 3)) begin n_fail++; $display("FAIL ovf_ready: write %0d got %b exp %b", i, video_ready, (i < 3)); end
        end
        idle_bus();
        n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b exp 1", ovf_err); end
        frame_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (frame_cs !== 1'b1 || frame_wr !== 1'b1 || frame_addr !== 20'(i) || frame_wr_data !== 32'hF0000000 + 32'(i)) begin
                n_fail++; $display("FAIL ovf_drain: entry %0d got cs=%b addr=%h data=%h exp cs=1 addr=%h", i, frame_cs, frame_addr, frame_wr_data, 20'(i)); end
            tick();
        end
        n_tests++; if (frame_cs !== 1'b0 || video_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_empty: got cs=%b ready=%b exp cs=0 ready=1", frame_cs, video_ready); end
        n_tests++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b exp 1", ovf_err); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            video_cs = 1'b1; video_wr = 1'b1; video_addr = 21'h100000 + 21'(i); video_wr_data = 32'(i);
            tick();
        end
        n_tests++; if (video_ready !== 1'b0) begin n_fail++; $display("FAIL pp_full: got %b exp 0", video_ready); end
        video_addr = 21'h100010; video_wr_data = 32'h55;
        frame_ready = 1'b1;
        tick();
        idle_bus();
        frame_ready = 1'b0;
        n_tests++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL pp_ovf: got %b exp 0", ovf_err); end
        n_tests++; if (video_ready !== 1'b0) begin n_fail++; $display("FAIL pp_count: ready got %b exp 0", video_ready); end
        frame_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (frame_addr !== ((i == 3) ? 20'h00010 : 20'(i + 1))) begin
                n_fail++; $display("FAIL pp_order: entry %0d got %h exp %h", i, frame_addr, (i == 3) ? 20'h00010 : 20'(i + 1)); end
            tick();
        end
        n_tests++; if (frame_cs !== 1'b0) begin n_fail++; $display("FAIL pp_empty: got %b exp 0", frame_cs); end
        frame_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        frame_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            video_cs = 1'b1; video_wr = 1'b1; video_addr = 21'h100040 + 21'(i); video_wr_data = 32'h77;
            tick();
        end
        video_wr = 1'b0; video_rd = 1'b1; video_addr = 21'h08000;
        tick();
        idle_bus();
        n_tests++; if (frame_cs !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b exp 1", frame_cs); end
        #3;
        reset_n = 1'b0;
        #1;
        n_tests++; if (frame_cs !== 1'b0 || frame_wr !== 1'b0) begin n_fail++; $display("FAIL mid_cs: got %b/%b exp 0/0", frame_cs, frame_wr); end
        n_tests++; if (video_ready !== 1'b1 || ovf_err !== 1'b0) begin n_fail++; $display("FAIL mid_flags: got ready=%b ovf=%b exp 1/0", video_ready, ovf_err); end
        n_tests++; if (video_rd_valid !== 1'b0 || slot_cs_array !== 8'h00) begin n_fail++; $display("FAIL mid_slot: got valid=%b cs=%h exp 0/00", video_rd_valid, slot_cs_array); end
        tick();
        reset_n = 1'b1;
        frame_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++; if (frame_cs !== 1'b0 || video_rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after: cycle %0d got cs=%b valid=%b exp 0/0", i, frame_cs, video_rd_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_slot_write();
        test_wr_and_rd();
        test_cs_low();
        test_read();
        test_frame_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
